xor_adder_arbiter: RTL and testbench

- Round-robin arbiter and sequencer sharing one xor_based_adder instance between NUM_REQ requesters, e.g. the encrypt u/v accumulation and the decrypt syndrome-add path.
- Grants one requester at a time and pulses the adder start.
- Steers the adder read port to the winner's operand memories and its write-back to the winner's result memory.
- Returns a per-requester done pulse when the adder finishes.

---
 rtl/hqc_common_pkg.sv | 23 ++
 rtl/xor_adder_arbiter_rr_pick.sv | 35 +++
 rtl/xor_adder_arbiter.sv | 121 ++++++++++++
 tb/tb_xor_adder_arbiter.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hqc_common_pkg.sv
// Shared HQC definitions: arbiter state encoding and the N / memory-depth
// derivation used by the adder, its memories and the arbiter.
package hqc_common_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_BUSY  = 2'd2,
      ST_DONE  = 2'd3
   } arb_state_t;

   function automatic int hqc_n(input string ps);
      if (ps == "hqc192") return 35851;
      if (ps == "hqc256") return 57637;
      return 17669;
   endfunction

   // Words per memory: N padded up to a whole number of WIDTH-bit words.
   function automatic int hqc_depth(input string ps, input int width);
      return (hqc_n(ps) + width - 1) / width;
   endfunction

endpackage

// File: rtl/xor_adder_arbiter_rr_pick.sv
// Cyclic priority encoder: first set request at or after rr_ptr, wrapping
// around, returned both one-hot and as an index.
module rr_pick #(
   parameter int NUM_REQ = 2,
   parameter int LOG_REQ = 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [LOG_REQ-1:0] rr_ptr,
   output logic [NUM_REQ-1:0] onehot,
   output logic [LOG_REQ-1:0] index,
   output logic               valid
);

   always_comb begin
      int   idx;
      logic found;
      // NOTE: every output gets a default before the loop so no path leaves
      // a value unassigned, which would otherwise infer a latch.
      idx    = 0;
      found  = 1'b0;
      onehot = '0;
      index  = '0;
      for (int off = 0; off < NUM_REQ; off++) begin
         idx = int'(rr_ptr) + off;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!found && req[LOG_REQ'(idx)]) begin
            found                 = 1'b1;
            onehot[LOG_REQ'(idx)] = 1'b1;
            index                 = LOG_REQ'(idx);
         end
      end
      valid = found;
   end

endmodule

// File: rtl/xor_adder_arbiter.sv
// Round-robin owner of one shared xor_based_adder: grants a requester, pulses
// the adder start, steers its memory ports and returns a per-requester done.
module xor_adder_arbiter
   import hqc_common_pkg::*;
#(
   parameter string parameter_set = "hqc128",
   parameter int    WIDTH         = 128,
   parameter int    NUM_REQ       = 2,
   parameter int    DEPTH         = hqc_depth(parameter_set, WIDTH),
   parameter int    LOG_DEPTH     = $clog2(DEPTH),
   parameter int    LOG_REQ       = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req,
   output logic [NUM_REQ-1:0]         grant,
   output logic [NUM_REQ-1:0]         req_done,
   output logic                       busy,
   input  logic [NUM_REQ*WIDTH-1:0]   req_in_1,
   input  logic [NUM_REQ*WIDTH-1:0]   req_in_2,
   output logic [LOG_DEPTH-1:0]       req_rd_addr,
   output logic [NUM_REQ-1:0]         req_rd_en,
   output logic [WIDTH-1:0]           req_wr_data,
   output logic [LOG_DEPTH-1:0]       req_wr_addr,
   output logic [NUM_REQ-1:0]         req_wr_en,
   output logic                       adder_start,
   output logic [WIDTH-1:0]           adder_in_1,
   output logic [WIDTH-1:0]           adder_in_2,
   input  logic [LOG_DEPTH-1:0]       adder_in_addr,
   input  logic                       adder_in_rd_en,
   input  logic [WIDTH-1:0]           adder_out,
   input  logic [LOG_DEPTH-1:0]       adder_out_addr,
   input  logic                       adder_out_valid,
   input  logic                       adder_done
);

   arb_state_t         state;
   logic [LOG_REQ-1:0] owner;
   logic [LOG_REQ-1:0] rr_ptr;
   logic [NUM_REQ-1:0] pick_onehot;
   logic [LOG_REQ-1:0] pick_index;
   logic               pick_valid;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .LOG_REQ (LOG_REQ)
   ) u_rr_pick (
      .req    (req),
      .rr_ptr (rr_ptr),
      .onehot (pick_onehot),
      .index  (pick_index),
      .valid  (pick_valid)
   );

   // NOTE: reset is synchronous and all state uses non-blocking assignments,
   // so every register updates from pre-edge values regardless of order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         grant       <= '0;
         req_done    <= '0;
         adder_start <= 1'b0;
         busy        <= 1'b0;
         owner       <= '0;
         rr_ptr      <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (pick_valid) begin
                  grant       <= pick_onehot;
                  owner       <= pick_index;
                  adder_start <= 1'b1;
                  busy        <= 1'b1;
                  state       <= ST_START;
               end
            end
            // adder_done seen while leaving START belongs to no operation.
            ST_START: begin
               adder_start <= 1'b0;
               state       <= ST_BUSY;
            end
            ST_BUSY: begin
               if (adder_done) begin
                  req_done[owner] <= 1'b1;
                  state           <= ST_DONE;
               end
            end
            ST_DONE: begin
               req_done <= '0;
               grant    <= '0;
               busy     <= 1'b0;
               rr_ptr   <= (owner == LOG_REQ'(NUM_REQ - 1)) ? '0 : owner + LOG_REQ'(1);
               state    <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Operand mux follows the registered owner; idle drives zeros.
   always_comb begin
      adder_in_1 = '0;
      adder_in_2 = '0;
      if (state != ST_IDLE) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (owner == LOG_REQ'(i)) begin
               adder_in_1 = req_in_1[i*WIDTH +: WIDTH];
               adder_in_2 = req_in_2[i*WIDTH +: WIDTH];
            end
         end
      end
   end

   // grant is all-zero in IDLE, so gating by it also blanks idle enables.
   assign req_rd_addr = adder_in_addr;
   assign req_rd_en   = {NUM_REQ{adder_in_rd_en}} & grant;
   assign req_wr_data = adder_out;
   assign req_wr_addr = adder_out_addr;
   assign req_wr_en   = {NUM_REQ{adder_out_valid}} & grant;

endmodule

// File: tb/tb_xor_adder_arbiter.sv
// Self-checking bench for xor_adder_arbiter with three requesters, a
// behavioural xor adder and per-requester operand/result memories.
module tb_xor_adder_arbiter;

   localparam int NR    = 3;
   localparam int W     = 128;
   localparam int DEPTH = 139;
   localparam int LD    = 8;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [NR-1:0]   req = '0;
   logic [NR-1:0]   grant, req_done, req_rd_en, req_wr_en;
   logic            busy, adder_start;
   logic [NR*W-1:0] req_in_1, req_in_2;
   logic [LD-1:0]   req_rd_addr, req_wr_addr;
   logic [W-1:0]    req_wr_data, adder_in_1, adder_in_2;
   logic [LD-1:0]   adder_in_addr, adder_out_addr;
   logic            adder_in_rd_en, adder_out_valid, adder_done;
   logic [W-1:0]    adder_out;

   always #5 clk = ~clk;

   xor_adder_arbiter #(
      .parameter_set ("hqc128"),
      .WIDTH         (W),
      .NUM_REQ       (NR)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .req             (req),
      .grant           (grant),
      .req_done        (req_done),
      .busy            (busy),
      .req_in_1        (req_in_1),
      .req_in_2        (req_in_2),
      .req_rd_addr     (req_rd_addr),
      .req_rd_en       (req_rd_en),
      .req_wr_data     (req_wr_data),
      .req_wr_addr     (req_wr_addr),
      .req_wr_en       (req_wr_en),
      .adder_start     (adder_start),
      .adder_in_1      (adder_in_1),
      .adder_in_2      (adder_in_2),
      .adder_in_addr   (adder_in_addr),
      .adder_in_rd_en  (adder_in_rd_en),
      .adder_out       (adder_out),
      .adder_out_addr  (adder_out_addr),
      .adder_out_valid (adder_out_valid),
      .adder_done      (adder_done)
   );

   int n_chk = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Requester memories: registered read, write on enable.
   logic [W-1:0] op1 [NR][DEPTH];
   logic [W-1:0] op2 [NR][DEPTH];
   logic [W-1:0] res [NR][DEPTH];
   logic [W-1:0] rd1 [NR];
   logic [W-1:0] rd2 [NR];

   always @(posedge clk) begin
      for (int r = 0; r < NR; r++) begin
         if (req_rd_en[r]) begin
            rd1[r] <= op1[r][req_rd_addr];
            rd2[r] <= op2[r][req_rd_addr];
         end
         if (req_wr_en[r]) res[r][req_wr_addr] <= req_wr_data;
      end
   end

   always_comb begin
      req_in_1 = '0;
      req_in_2 = '0;
      for (int r = 0; r < NR; r++) begin
         req_in_1[r*W +: W] = rd1[r];
         req_in_2[r*W +: W] = rd2[r];
      end
   end

   // Behavioural adder: sweep reads 0..DEPTH-1, result one cycle after read.
   logic          run, vld_d, a_done;
   int            rd_cnt;
   logic [LD-1:0] addr_d;
   logic          stub_mode = 1'b0;
   logic          stub_done = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         run    <= 1'b0;
         rd_cnt <= 0;
         vld_d  <= 1'b0;
         addr_d <= '0;
         a_done <= 1'b0;
      end else begin
         vld_d  <= adder_in_rd_en;
         addr_d <= adder_in_addr;
         a_done <= vld_d && (addr_d == LD'(DEPTH - 1));
         if (adder_start && !stub_mode) begin
            run    <= 1'b1;
            rd_cnt <= 0;
         end else if (run) begin
            if (rd_cnt == DEPTH - 1) run <= 1'b0;
            rd_cnt <= rd_cnt + 1;
         end
      end
   end

   assign adder_in_rd_en  = run;
   assign adder_in_addr   = LD'(rd_cnt);
   assign adder_out       = adder_in_1 ^ adder_in_2;
   assign adder_out_addr  = addr_d;
   assign adder_out_valid = vld_d;
   assign adder_done      = a_done | stub_done;

   // Monitor: write counts, address order, done pulses, grant scoreboard.
   int             wr_cnt   [NR];
   int             exp_addr [NR];
   int             done_cnt [NR];
   int             addr_err = 0;
   logic           sb_en    = 1'b0;
   logic [NR-1:0]  grant_prev = '0;
   logic [NR-1:0]  exp_q [$];

   initial for (int r = 0; r < NR; r++) begin
      wr_cnt[r] = 0; exp_addr[r] = 0; done_cnt[r] = 0;
   end

   always @(posedge clk) begin
      for (int r = 0; r < NR; r++) begin
         if (req_wr_en[r] === 1'b1) begin
            if (req_wr_addr !== LD'(exp_addr[r])) addr_err++;
            exp_addr[r]++;
            wr_cnt[r]++;
         end
         if (req_done[r] === 1'b1) done_cnt[r]++;
      end
      if (sb_en && grant !== '0 && grant_prev === '0) begin
         if (exp_q.size() == 0) check("sb_unexpected_grant", grant, '0);
         else check("sb_grant_order", grant, exp_q.pop_front());
      end
      grant_prev = grant;
   end

   task automatic clear_counts();
      for (int r = 0; r < NR; r++) begin
         wr_cnt[r] = 0; exp_addr[r] = 0;
      end
      addr_err = 0;
   endtask

   task automatic rand_ops();
      for (int r = 0; r < NR; r++)
         for (int a = 0; a < DEPTH; a++) begin
            op1[r][a] = {$urandom(), $urandom(), $urandom(), $urandom()};
            op2[r][a] = {$urandom(), $urandom(), $urandom(), $urandom()};
         end
   endtask

   function automatic int bad_words(input int r);
      int bad = 0;
      for (int a = 0; a < DEPTH; a++)
         if (res[r][a] !== (op1[r][a] ^ op2[r][a])) bad++;
      return bad;
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // Returns at the negedge where req_done is seen, or 0 after the budget.
   task automatic wait_done(output logic [NR-1:0] got);
      got = '0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (req_done !== '0) begin
            got = req_done;
            break;
         end
      end
   endtask

   typedef struct {
      logic [NR-1:0] req;
      logic [NR-1:0] grant;
   } vec_t;

   vec_t          vecs [8];
   logic [NR-1:0] got;
   int            owner, others, d0, found;

   initial begin
      // rr_ptr walk from reset: 0 ->1 ->1 ->0 ->2 ->1 ->2 ->0 ->2
      vecs[0] = '{req: 3'b001, grant: 3'b001};
      vecs[1] = '{req: 3'b001, grant: 3'b001};
      vecs[2] = '{req: 3'b101, grant: 3'b100};
      vecs[3] = '{req: 3'b110, grant: 3'b010};
      vecs[4] = '{req: 3'b011, grant: 3'b001};
      vecs[5] = '{req: 3'b111, grant: 3'b010};
      vecs[6] = '{req: 3'b100, grant: 3'b100};
      vecs[7] = '{req: 3'b010, grant: 3'b010};

      do_reset();
      check("reset_grant", grant, '0);
      check("reset_busy", busy, 0);
      check("reset_start", adder_start, 0);
      check("reset_done", req_done, '0);
      check("idle_rd_en", req_rd_en, '0);
      check("idle_mux", adder_in_1, '0);

      for (int v = 0; v < 8; v++) begin
         owner = 0;
         for (int r = 0; r < NR; r++) if (vecs[v].grant[r]) owner = r;
         rand_ops();
         clear_counts();
         req = vecs[v].req;
         @(posedge clk); #1;
         check($sformatf("vec%0d_grant", v), grant, vecs[v].grant);
         check($sformatf("vec%0d_start", v), adder_start, 1);
         check($sformatf("vec%0d_busy", v), busy, 1);
         @(posedge clk); #1;
         check($sformatf("vec%0d_start_width", v), adder_start, 0);
         wait_done(got);
         check($sformatf("vec%0d_done", v), got, vecs[v].grant);
         req = '0;
         repeat (2) @(negedge clk);
         others = 0;
         for (int r = 0; r < NR; r++) if (r != owner) others += wr_cnt[r];
         check($sformatf("vec%0d_wr_cnt", v), wr_cnt[owner], DEPTH);
         check($sformatf("vec%0d_other_wr", v), others, 0);
         check($sformatf("vec%0d_addr_order", v), addr_err, 0);
         check($sformatf("vec%0d_result", v), bad_words(owner), 0);
         check($sformatf("vec%0d_idle", v), busy, 0);
      end

      // Two requests from reset: 0 first, 1 granted two cycles after done.
      do_reset();
      rand_ops();
      req = 3'b011;
      wait_done(got);
      check("b2b_first_done", got, 3'b001);
      @(negedge clk);
      check("b2b_gap_grant", grant, '0);
      @(negedge clk);
      check("b2b_second_grant", grant, 3'b010);
      wait_done(got);
      check("b2b_second_done", got, 3'b010);
      req = '0;
      repeat (2) @(negedge clk);
      check("b2b_result0", bad_words(0), 0);
      check("b2b_result1", bad_words(1), 0);

      // All requests held: owners rotate 0,1,2,0,1.
      do_reset();
      sb_en = 1'b1;
      exp_q.push_back(3'b001); exp_q.push_back(3'b010); exp_q.push_back(3'b100);
      exp_q.push_back(3'b001); exp_q.push_back(3'b010);
      req = 3'b111;
      for (int k = 0; k < 5; k++) begin
         wait_done(got);
         check($sformatf("rot%0d_done", k), got, 3'b001 << (k % 3));
         if (k == 4) req = '0;
      end
      repeat (3) @(negedge clk);
      sb_en = 1'b0;
      check("rot_queue_empty", exp_q.size(), 0);
      check("rot_idle", busy, 0);

      // Request dropped during BUSY: operation still completes.
      do_reset();
      rand_ops();
      clear_counts();
      req = 3'b001;
      repeat (10) @(negedge clk);
      check("drop_busy", busy, 1);
      req = '0;
      wait_done(got);
      check("drop_done", got, 3'b001);
      repeat (2) @(negedge clk);
      check("drop_idle_busy", busy, 0);
      check("drop_idle_grant", grant, '0);
      check("drop_result", bad_words(0), 0);

      // Reset mid-BUSY at read address 60, then a fresh full operation.
      do_reset();
      rand_ops();
      req = 3'b001;
      found = 0;
      for (int i = 0; i < 300 && found == 0; i++) begin
         @(negedge clk);
         if (adder_in_rd_en && adder_in_addr == LD'(60)) found = 1;
      end
      check("rst_mid_reached60", found, 1);
      req = '0;
      d0 = done_cnt[0];
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst_mid_grant", grant, '0);
      check("rst_mid_busy", busy, 0);
      repeat (5) @(negedge clk);
      check("rst_mid_no_done", done_cnt[0], d0);
      rand_ops();
      clear_counts();
      req = 3'b001;
      wait_done(got);
      check("rst_rereq_done", got, 3'b001);
      req = '0;
      repeat (2) @(negedge clk);
      check("rst_rereq_wr_cnt", wr_cnt[0], DEPTH);
      check("rst_rereq_addr", addr_err, 0);
      check("rst_rereq_result", bad_words(0), 0);

      // Spurious adder_done during START is ignored.
      stub_mode = 1'b1;
      do_reset();
      d0 = done_cnt[0];
      req = 3'b001;
      @(posedge clk); #1;
      check("stub_start", adder_start, 1);
      stub_done = 1'b1;
      @(posedge clk); #1;
      stub_done = 1'b0;
      repeat (5) @(negedge clk);
      check("stub_still_busy", busy, 1);
      check("stub_grant_held", grant, 3'b001);
      check("stub_no_done", done_cnt[0], d0);
      stub_done = 1'b1;
      @(negedge clk);
      stub_done = 1'b0;
      check("stub_real_done", req_done, 3'b001);
      req = '0;
      repeat (2) @(negedge clk);
      check("stub_idle", busy, 0);
      stub_mode = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_err, n_chk);
      $fatal(1, "watchdog");
   end

endmodule
